// File: rtl/tc_pkg.sv
// Shared definitions for the thermocouple moving-average stage.
// Optional build macro TC_AVG_ROUND_EN enables round-half-up output.
package tc_pkg;

   localparam logic [1:0] TC_AVG_EMPTY = 2'd0;
   localparam logic [1:0] TC_AVG_FILL  = 2'd1;
   localparam logic [1:0] TC_AVG_RUN   = 2'd2;

   localparam int TC_WORD_SIZE = 16;

   function automatic int tc_sum_width(
      input int word_size,
      input int log2_depth
   );
      return word_size + log2_depth;
   endfunction

endpackage

// File: rtl/tc_avg_ring.sv
// Circular sample buffer for tc_avg: write port, read at ptr, ptr counter.
// Contents are deliberately left unreset; only the pointer clears.
module tc_avg_ring
   import tc_pkg::*;
#(
   parameter int WORD_SIZE  = TC_WORD_SIZE,
   parameter int LOG2_DEPTH = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_clr,
   input  logic                 i_wr,
   input  logic [WORD_SIZE-1:0] i_data,
   output logic [WORD_SIZE-1:0] o_old
);

   localparam int DEPTH = 1 << LOG2_DEPTH;

   logic [WORD_SIZE-1:0]  mem [DEPTH];
   logic [LOG2_DEPTH-1:0] ptr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr <= '0;
      end else if (i_clr) begin
         ptr <= '0;
      end else if (i_wr) begin
         ptr <= ptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_wr) begin
         mem[ptr] <= i_data;
      end
   end

   assign o_old = mem[ptr];

endmodule

// File: rtl/tc_avg.sv
// Boxcar moving average over 2^LOG2_DEPTH samples, two-stage pipeline.
// Build macro TC_AVG_ROUND_EN selects rounding instead of truncation.
module tc_avg
   import tc_pkg::*;
#(
   parameter int WORD_SIZE  = TC_WORD_SIZE,
   parameter int LOG2_DEPTH = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [WORD_SIZE-1:0] i_temp,
   input  logic                 i_stb,
   input  logic                 i_clr,
   output logic [WORD_SIZE-1:0] o_temp,
   output logic                 o_stb,
   output logic                 o_full
);

   localparam int SW    = tc_sum_width(WORD_SIZE, LOG2_DEPTH);
   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int CW    = LOG2_DEPTH + 1;

   logic [1:0]           state;
   logic [1:0]           state_nxt;
   logic [SW-1:0]        sum;
   logic [SW-1:0]        sum_nxt;
   logic [WORD_SIZE-1:0] seed;
   logic [WORD_SIZE-1:0] old;
   logic [CW-1:0]        count;
   logic [CW-1:0]        count_nxt;
   logic                 full_set;
   logic                 vld;
   logic                 accept;
   logic [WORD_SIZE-1:0] avg;

   assign accept = i_stb & ~i_clr;

   tc_avg_ring #(
      .WORD_SIZE  (WORD_SIZE),
      .LOG2_DEPTH (LOG2_DEPTH)
   ) u_ring (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (i_clr),
      .i_wr    (accept),
      .i_data  (i_temp),
      .o_old   (old)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= TC_AVG_EMPTY;
      end else if (i_clr) begin
         state <= TC_AVG_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (accept) begin
         unique case (state)
            TC_AVG_EMPTY: state_nxt = TC_AVG_FILL;
            TC_AVG_FILL:
               if (count == CW'(DEPTH - 1))
                  state_nxt = TC_AVG_RUN;
            TC_AVG_RUN:   state_nxt = TC_AVG_RUN;
            default:      state_nxt = TC_AVG_EMPTY;
         endcase
      end
   end

   // Seed copies stand in for samples not yet received during FILL.
   always_comb begin
      sum_nxt   = sum;
      count_nxt = count;
      full_set  = 1'b0;
      unique case (state)
         TC_AVG_EMPTY: begin
            sum_nxt   = SW'(i_temp) << LOG2_DEPTH;
            count_nxt = CW'(1);
         end
         TC_AVG_FILL: begin
            sum_nxt   = sum + SW'(i_temp) - SW'(seed);
            count_nxt = count + 1'b1;
            full_set  = (count == CW'(DEPTH - 1));
         end
         TC_AVG_RUN: begin
            sum_nxt   = sum + SW'(i_temp) - SW'(old);
         end
         default: begin
            sum_nxt   = '0;
            count_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sum    <= '0;
         seed   <= '0;
         count  <= '0;
         o_full <= 1'b0;
         vld    <= 1'b0;
      end else if (i_clr) begin
         sum    <= '0;
         count  <= '0;
         o_full <= 1'b0;
         vld    <= 1'b0;
      end else begin
         vld <= accept;
         if (accept) begin
            sum   <= sum_nxt;
            count <= count_nxt;
            if (state == TC_AVG_EMPTY)
               seed <= i_temp;
            if (full_set)
               o_full <= 1'b1;
         end
      end
   end

`ifdef TC_AVG_ROUND_EN
   logic [SW:0]        rsum;
   logic [WORD_SIZE:0] rq;

   // One extra bit absorbs the half-LSB carry; clamp if it is ever set.
   assign rsum = {1'b0, sum} + (SW + 1)'(1 << (LOG2_DEPTH - 1));
   assign rq   = (WORD_SIZE + 1)'(rsum >> LOG2_DEPTH);
   assign avg  = rq[WORD_SIZE] ? '1 : rq[WORD_SIZE-1:0];
`else
   assign avg = WORD_SIZE'(sum >> LOG2_DEPTH);
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_temp <= '0;
         o_stb  <= 1'b0;
      end else if (i_clr) begin
         o_temp <= '0;
         o_stb  <= 1'b0;
      end else begin
         o_stb <= vld;
         if (vld)
            o_temp <= avg;
      end
   end

endmodule

// File: tb/tb_tc_avg.sv
// Directed self-checking bench for tc_avg (WORD_SIZE=16, LOG2_DEPTH=2).
// Expected rounding results follow TC_AVG_ROUND_EN when defined.
module tb_tc_avg;

   logic        i_clk;
   logic        i_rst_n;
   logic [15:0] i_temp;
   logic        i_stb;
   logic        i_clr;
   logic [15:0] o_temp;
   logic        o_stb;
   logic        o_full;

   int checks;
   int failures;
   int qt[$];
   int qf[$];

   tc_avg #(
      .WORD_SIZE  (16),
      .LOG2_DEPTH (2)
   ) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_temp  (i_temp),
      .i_stb   (i_stb),
      .i_clr   (i_clr),
      .o_temp  (o_temp),
      .o_stb   (o_stb),
      .o_full  (o_full)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      if (o_stb) begin
         qt.push_back(int'(o_temp));
         qf.push_back(int'(o_full));
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send(input int v);
      @(negedge i_clk);
      i_stb  = 1'b1;
      i_temp = 16'(v);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge i_clk);
         i_stb = 1'b0;
      end
   endtask

   task automatic expect_out(input string tag, input int et, input int ef);
      int t;
      int f;
      for (int i = 0; i < 10 && qt.size() == 0; i++)
         @(posedge i_clk);
      chk({tag, "_seen"}, int'(qt.size() > 0), 1);
      if (qt.size() > 0) begin
         t = qt.pop_front();
         f = qf.pop_front();
         chk(tag, t, et);
         if (ef >= 0)
            chk({tag, "_full"}, f, ef);
      end
   endtask

   task automatic clear();
      @(negedge i_clk);
      i_clr = 1'b1;
      i_stb = 1'b0;
      @(negedge i_clk);
      i_clr = 1'b0;
      idle(3);
      qt.delete();
      qf.delete();
   endtask

   int rnd_exp;

   initial begin
      checks   = 0;
      failures = 0;
      i_rst_n  = 1'b0;
      i_temp   = '0;
      i_stb    = 1'b0;
      i_clr    = 1'b0;
`ifdef TC_AVG_ROUND_EN
      rnd_exp = 2;
`else
      rnd_exp = 1;
`endif
      repeat (2) @(negedge i_clk);
      chk("rst_temp", int'(o_temp), 0);
      chk("rst_stb", int'(o_stb), 0);
      chk("rst_full", int'(o_full), 0);
      i_rst_n = 1'b1;

      // single sample latency
      send(100);
      @(negedge i_clk);
      i_stb = 1'b0;
      chk("lat_early", int'(o_stb), 0);
      @(negedge i_clk);
      chk("lat_stb", int'(o_stb), 1);
      chk("lat_temp", int'(o_temp), 100);
      chk("lat_full", int'(o_full), 0);
      @(negedge i_clk);
      chk("lat_pulse", int'(o_stb), 0);
      chk("lat_hold", int'(o_temp), 100);
      qt.delete();
      qf.delete();

      // fill, run and wrap
      clear();
      send(100);
      send(200);
      send(300);
      send(400);
      send(500);
      send(600);
      idle(1);
      expect_out("fill1", 100, 0);
      expect_out("fill2", 125, 0);
      expect_out("fill3", 175, -1);
      expect_out("fill4", 250, 1);
      expect_out("run5", 350, 1);
      expect_out("run6", 450, 1);
      idle(2);

      // clear wins over a simultaneous sample
      @(negedge i_clk);
      i_clr  = 1'b1;
      i_stb  = 1'b1;
      i_temp = 16'd900;
      @(negedge i_clk);
      i_clr = 1'b0;
      i_stb = 1'b0;
      chk("clr_temp", int'(o_temp), 0);
      chk("clr_full", int'(o_full), 0);
      chk("clr_stb", int'(o_stb), 0);
      idle(4);
      chk("clr_drop", qt.size(), 0);
      send(40);
      idle(1);
      expect_out("clr_next", 40, 0);

      // reset with a sample held in stage 1
      send(80);
      @(posedge i_clk);
      #1;
      i_stb   = 1'b0;
      i_rst_n = 1'b0;
      #1;
      chk("arst_temp", int'(o_temp), 0);
      chk("arst_stb", int'(o_stb), 0);
      chk("arst_full", int'(o_full), 0);
      idle(3);
      chk("arst_nostb", qt.size(), 0);
      i_rst_n = 1'b1;
      send(7);
      idle(1);
      expect_out("arst_next", 7, 0);

      // rounding vs truncation
      clear();
      send(1);
      send(3);
      idle(1);
      expect_out("rnd_a", 1, 0);
      expect_out("rnd_b", rnd_exp, 0);

      // full-scale input, no overflow
      clear();
      for (int i = 0; i < 6; i++)
         send(65535);
      idle(1);
      for (int i = 0; i < 6; i++)
         expect_out($sformatf("max%0d", i), 65535, -1);

      idle(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
